// File: rtl/float_params.sv
// Shared FP32 format constants and FSM state encoding for the float unit responders.
package float_params;
  localparam int float_width      = 32;
  localparam int float_exp_width  = 8;
  localparam int float_mant_width = 23;
  localparam int float_exp_bias   = 127;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ALIGN,
    ST_ADD,
    ST_NORM,
    ST_DONE
  } float_state_t;
endpackage

// File: rtl/float_add_norm.sv
// Leading-zero count and left-justify of the adder's un-carried mantissa sum (purely combinational).
module float_add_norm #(
  parameter int W   = 24,
  parameter int LZW = $clog2(W + 1)
) (
  input  logic [W-1:0]   mant_in,
  output logic [W-1:0]   mant_out,
  output logic [LZW-1:0] lzc
);
  always_comb begin
    lzc = LZW'(W);
    // Ascending scan: the highest set bit is the last one to write lzc.
    for (int i = 0; i < W; i++) begin
      if (mant_in[i]) lzc = LZW'(W - 1 - i);
    end
    mant_out = mant_in << lzc;
  end
endmodule

// File: rtl/float_add_pipeline.sv
// FP32 adder responder on the float req/ack protocol: one op in flight, ack 4 clocks after the req edge.
// Define FLOAT_ADD_RNE_EN for round-to-nearest-even; otherwise the mantissa is truncated toward zero.
module float_add_pipeline
  import float_params::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req,
  input  logic [float_width-1:0] a,
  input  logic [float_width-1:0] b,
  output logic                   busy,
  output logic                   ack,
  output logic [float_width-1:0] out
);
`ifdef FLOAT_ADD_RNE_EN
  localparam int GRS = 3;
`else
  localparam int GRS = 0;
`endif
  localparam int EW  = float_exp_width;
  localparam int FW  = float_mant_width;
  localparam int MW  = FW + 1 + GRS;
  localparam int LZW = $clog2(MW + 1);
  localparam logic signed [EW+1:0] NE_ONE = 1;
  localparam logic signed [EW+1:0] NE_ZERO = 0;
  localparam logic signed [EW+1:0] NE_INF = (1 << EW) - 1;

  float_state_t state_q, state_d;
  logic busy_q, busy_d, ack_q, ack_d;
  logic [float_width-1:0] out_q, out_d;
  logic sa_q, sa_d, sb_q, sb_d;
  logic [EW-1:0] ea_q, ea_d, eb_q, eb_d;
  logic [FW:0] ma_q, ma_d, mb_q, mb_d;
  logic s_q, s_d, sub_q, sub_d;
  logic [EW-1:0] e_q, e_d;
  logic [MW-1:0] bm_q, bm_d, sm_q, sm_d;
  logic [MW:0] sum_q, sum_d;

  logic swap, big_s;
  logic [EW-1:0] big_e, sml_e, diff;
  logic [FW:0] big_m, sml_m;
  logic [MW-1:0] sml_ext, sml_sh, norm_m;
  logic [LZW-1:0] lzc;
  logic signed [EW+1:0] ne;
  logic [FW-1:0] frac;
  logic is_zero;
  logic [float_width-1:0] res;
`ifdef FLOAT_ADD_RNE_EN
  logic sticky;
  logic [MW-1:0] nm;
  logic [FW+1:0] rnd;
`endif

  float_add_norm #(.W(MW), .LZW(LZW)) u_norm (
    .mant_in (sum_q[MW-1:0]),
    .mant_out(norm_m),
    .lzc     (lzc)
  );

  // Alignment: order by magnitude, then right-shift the smaller mantissa.
  always_comb begin
    swap    = {eb_q, mb_q} > {ea_q, ma_q};
    big_s   = swap ? sb_q : sa_q;
    big_e   = swap ? eb_q : ea_q;
    big_m   = swap ? mb_q : ma_q;
    sml_e   = swap ? ea_q : eb_q;
    sml_m   = swap ? ma_q : mb_q;
    diff    = big_e - sml_e;
    sml_ext = MW'(sml_m) << GRS;
    if (diff >= EW'(26)) sml_sh = '0;
    else                 sml_sh = sml_ext >> diff;
`ifdef FLOAT_ADD_RNE_EN
    if (diff >= EW'(26)) sticky = |sml_m;
    else                 sticky = (sml_sh << diff) != sml_ext;
`endif
  end

  // Normalisation, optional rounding, and special-case packing of the result.
  always_comb begin
    is_zero = ~(sum_q[MW] | norm_m[MW-1]);
    if (sum_q[MW]) ne = $signed({2'b00, e_q}) + NE_ONE;
    else           ne = $signed({2'b00, e_q}) - $signed({{(EW+2-LZW){1'b0}}, lzc});
`ifdef FLOAT_ADD_RNE_EN
    if (sum_q[MW]) nm = {sum_q[MW:2], sum_q[1] | sum_q[0]};
    else           nm = norm_m;
    rnd = {1'b0, nm[MW-1:GRS]} + {{(FW+1){1'b0}}, nm[2] & (nm[1] | nm[0] | nm[3])};
    if (rnd[FW+1]) begin
      frac = rnd[FW:1];
      ne   = ne + NE_ONE;
    end else begin
      frac = rnd[FW-1:0];
    end
`else
    if (sum_q[MW]) frac = sum_q[MW-1:1];
    else           frac = norm_m[MW-2:0];
`endif
    if (is_zero)            res = '0;
    else if (ne <= NE_ZERO) res = {s_q, {(float_width-1){1'b0}}};
    else if (ne >= NE_INF)  res = {s_q, {EW{1'b1}}, {FW{1'b0}}};
    else                    res = {s_q, ne[EW-1:0], frac};
  end

  always_comb begin
    state_d = state_q;
    busy_d  = (state_q != ST_IDLE);
    ack_d   = (state_q == ST_DONE);
    out_d   = out_q;
    sa_d = sa_q;  ea_d = ea_q;  ma_d = ma_q;
    sb_d = sb_q;  eb_d = eb_q;  mb_d = mb_q;
    s_d  = s_q;   sub_d = sub_q; e_d = e_q;
    bm_d = bm_q;  sm_d = sm_q;   sum_d = sum_q;
    case (state_q)
      ST_IDLE: if (req) begin
        sa_d    = a[float_width-1];
        ea_d    = a[float_width-2 -: EW];
        ma_d    = (a[float_width-2 -: EW] == '0) ? '0 : {1'b1, a[FW-1:0]};
        sb_d    = b[float_width-1];
        eb_d    = b[float_width-2 -: EW];
        mb_d    = (b[float_width-2 -: EW] == '0) ? '0 : {1'b1, b[FW-1:0]};
        state_d = ST_ALIGN;
      end
      ST_ALIGN: begin
        s_d   = big_s;
        e_d   = big_e;
        sub_d = sa_q ^ sb_q;
        bm_d  = MW'(big_m) << GRS;
`ifdef FLOAT_ADD_RNE_EN
        sm_d  = sml_sh | MW'(sticky);
`else
        sm_d  = sml_sh;
`endif
        state_d = ST_ADD;
      end
      ST_ADD: begin
        sum_d   = sub_q ? ({1'b0, bm_q} - {1'b0, sm_q}) : ({1'b0, bm_q} + {1'b0, sm_q});
        state_d = ST_NORM;
      end
      ST_NORM: begin
        out_d   = res;
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      out_q   <= '0;
      sa_q <= 1'b0;  ea_q <= '0;  ma_q <= '0;
      sb_q <= 1'b0;  eb_q <= '0;  mb_q <= '0;
      s_q  <= 1'b0;  sub_q <= 1'b0; e_q <= '0;
      bm_q <= '0;    sm_q <= '0;    sum_q <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      out_q   <= out_d;
      sa_q <= sa_d;  ea_q <= ea_d;  ma_q <= ma_d;
      sb_q <= sb_d;  eb_q <= eb_d;  mb_q <= mb_d;
      s_q  <= s_d;   sub_q <= sub_d; e_q <= e_d;
      bm_q <= bm_d;  sm_q <= sm_d;   sum_q <= sum_d;
    end
  end

  assign busy = busy_q;
  assign ack  = ack_q;
  assign out  = out_q;
endmodule

// File: tb/tb_float_add_pipeline.sv
// Scoreboard bench for float_add_pipeline: directed corner cases plus random operands vs a real-valued model.
module tb_float_add_pipeline;
  logic        clk = 1'b0;
  logic        rst, req;
  logic [31:0] a, b, out;
  logic        busy, ack;

  float_add_pipeline dut (
    .clk (clk),
    .rst (rst),
    .req (req),
    .a   (a),
    .b   (b),
    .busy(busy),
    .ack (ack),
    .out (out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, passes = 0, ack_seen = 0, ack_expected = 0;
  logic [31:0] q_bits[$];
  bit          q_exact[$];
  real         q_val[$];
  real         q_tol[$];
  int          q_cyc[$];

  logic [31:0] m_bits;
  bit          m_exact;
  real         m_val, m_tol, m_got;
  int          m_cyc;

  function automatic real fabs(input real x);
    return (x < 0.0) ? -x : x;
  endfunction

  // Value of an FP32 pattern with denormals treated as zero.
  function automatic real to_real(input logic [31:0] x);
    real r;
    int  e;
    if (x[30:23] == 8'd0) return 0.0;
    r = 1.0 + real'(x[22:0]) / 8388608.0;
    e = int'(x[30:23]) - 127;
    if (e > 0) for (int i = 0; i < e; i++) r = r * 2.0;
    else       for (int i = 0; i < -e; i++) r = r / 2.0;
    return x[31] ? -r : r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h, required %h", name, got, exp);
  endtask

  // Drives a one-cycle req and records the expected response; returns 1ns after the sampling edge.
  task automatic issue(input logic [31:0] xa, input logic [31:0] xb, input bit exact,
                       input logic [31:0] ebits);
    real ra, rb;
    a = xa; b = xb; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    ra = to_real(xa);
    rb = to_real(xb);
    q_bits.push_back(ebits);
    q_exact.push_back(exact);
    q_val.push_back(ra + rb);
    q_tol.push_back(((fabs(ra) > fabs(rb)) ? fabs(ra) : fabs(rb)) / 2097152.0);
    q_cyc.push_back(cyc + 4);
    ack_expected++;
  endtask

  task automatic send(input logic [31:0] xa, input logic [31:0] xb, input bit exact,
                      input logic [31:0] ebits);
    issue(xa, xb, exact, ebits);
    repeat (4) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (ack === 1'b1) begin
      ack_seen++;
      if (q_bits.size() == 0) begin
        checks++;
        $display("FAIL unexpected_ack: ack at cycle %0d with nothing outstanding", cyc);
      end else begin
        m_bits  = q_bits.pop_front();
        m_exact = q_exact.pop_front();
        m_val   = q_val.pop_front();
        m_tol   = q_tol.pop_front();
        m_cyc   = q_cyc.pop_front();
        m_got   = to_real(out);
        checks++;
        if (m_exact) begin
          if (out === m_bits) passes++;
          else $display("FAIL result_exact: out=%h, required %h", out, m_bits);
        end else begin
          if (fabs(m_got - m_val) <= m_tol) passes++;
          else $display("FAIL result_near: out=%h (%g), required %g +/- %g", out, m_got, m_val, m_tol);
        end
        checks++;
        if (cyc == m_cyc) passes++;
        else $display("FAIL ack_latency: ack at cycle %0d, required cycle %0d", cyc, m_cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] xa, xb;
    rst = 1'b1; req = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_ack", {31'b0, ack}, 32'd0);
    check("reset_out", out, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1.5 + 2.25 with cycle-by-cycle busy/ack timing
    issue(32'h3FC00000, 32'h40100000, 1, 32'h40700000);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("busy_k%0d", k), {31'b0, busy}, {31'b0, (k >= 1 && k <= 4)});
      check($sformatf("ack_k%0d", k), {31'b0, ack}, {31'b0, (k == 4)});
    end
    @(posedge clk); #1;

    send(32'h42C80000, 32'hC2C80000, 1, 32'h00000000);  // 100 - 100
    send(32'h00000000, 32'h00000000, 1, 32'h00000000);  // 0 + 0
    send(32'h80000000, 32'h80000000, 1, 32'h00000000);  // -0 + -0
    send(32'h3F800000, 32'h30800000, 1, 32'h3F800000);  // 1 + 2^-30
    send(32'h00400000, 32'h3F800000, 1, 32'h3F800000);  // denormal flushed
    send(32'h00800000, 32'h80C00000, 1, 32'h80000000);  // underflow to -0
    send(32'hC4FA0000, 32'h40133333, 0, 32'h0);         // -2000 + 2.3
    send(32'h40000000, 32'hC0133333, 0, 32'h0);         // 2.0 - 2.3

    // overflow to inf, with a second req while busy that must be ignored
    issue(32'h7F7FFFFF, 32'h7F7FFFFF, 1, 32'h7F800000);
    @(posedge clk); #1;
    a = 32'h3F800000; b = 32'h3F800000; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // back-to-back ops every 5 cycles
    send(32'h3F800000, 32'h40000000, 1, 32'h40400000);  // 1 + 2
    send(32'hC0400000, 32'h3F800000, 1, 32'hC0000000);  // -3 + 1

    // reset mid-operation: no ack, out and busy cleared
    a = 32'h40000000; b = 32'h40000000; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("async_rst_busy", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("post_rst_out", out, 32'h0);
    check("post_rst_busy", {31'b0, busy}, 32'd0);
    send(32'h40000000, 32'h40000000, 1, 32'h40800000);  // 2 + 2 after reset

    for (int i = 0; i < 40; i++) begin
      xa = {1'($urandom_range(0, 1)), 8'($urandom_range(110, 144)), 23'($urandom)};
      case (i % 4)
        0:       xb = {~xa[31], xa[30:0]};
        1:       xb = {~xa[31], xa[30:23], 23'($urandom)};
        default: xb = {1'($urandom_range(0, 1)), 8'($urandom_range(110, 144)), 23'($urandom)};
      endcase
      send(xa, xb, (i % 4 == 0), 32'h0);
    end

    for (int w = 0; w < 20 && q_bits.size() != 0; w++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 32'(q_bits.size()), 32'd0);
    check("ack_count", 32'(ack_seen), 32'(ack_expected));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
